// File: rtl/cpu_ctl_pkg.sv
// Shared control definitions for the RV32I control units (single-cycle decoder and the
// multi-cycle sequencer): opcodes, ALU-op and mux-select encodings, FSM states, trap causes.
package cpu_ctl_pkg;

  // Major opcodes
  localparam logic [6:0] OpcodeOp     = 7'b0110011;
  localparam logic [6:0] OpcodeOpImm  = 7'b0010011;
  localparam logic [6:0] OpcodeLoad   = 7'b0000011;
  localparam logic [6:0] OpcodeStore  = 7'b0100011;
  localparam logic [6:0] OpcodeBranch = 7'b1100011;
  localparam logic [6:0] OpcodeJal    = 7'b1101111;
  localparam logic [6:0] OpcodeJalr   = 7'b1100111;
  localparam logic [6:0] OpcodeLui    = 7'b0110111;
  localparam logic [6:0] OpcodeAuipc  = 7'b0010111;

  localparam logic [6:0] Funct7Base = 7'b0000000;
  localparam logic [6:0] Funct7Alt  = 7'b0100000;

  // ALU operations
  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluXor  = 4'b0011;
  localparam logic [3:0] AluSll  = 4'b0100;
  localparam logic [3:0] AluSrl  = 4'b0101;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluSlt  = 4'b0111;
  localparam logic [3:0] AluSltu = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1001;

  // Immediate formats
  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmU = 3'b011;
  localparam logic [2:0] ImmJ = 3'b100;

  // Next-PC, writeback and ALU operand selects
  localparam logic [1:0] PcPlus4  = 2'b00;
  localparam logic [1:0] PcBranch = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  localparam logic [1:0] WbAlu = 2'b00;
  localparam logic [1:0] WbMem = 2'b01;
  localparam logic [1:0] WbPc4 = 2'b10;

  localparam logic [1:0] SrcARs1  = 2'b00;
  localparam logic [1:0] SrcAPc   = 2'b01;
  localparam logic [1:0] SrcAZero = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  // Trap causes
  localparam logic [1:0] TrapNone    = 2'b00;
  localparam logic [1:0] TrapIllegal = 2'b01;
  localparam logic [1:0] TrapTimeout = 2'b10;

  typedef enum logic [2:0] {
    StFetch, StDecode, StExecute, StMem, StWb, StTrap
  } ctl_state_e;

  typedef enum logic [3:0] {
    ClsOp, ClsOpImm, ClsLoad, ClsStore, ClsBranch, ClsJal, ClsJalr, ClsLui, ClsAuipc,
    ClsIllegal
  } instr_class_e;

  // funct3/funct7 to ALU op. SUB only exists for register-register; SRA/SRAI both use alt.
  function automatic logic [3:0] alu_from_funct(input logic [2:0] funct3, input logic alt,
                                                input logic is_reg);
    logic [3:0] op;
    op = AluAdd;
    case (funct3)
      3'b000: op = (alt && is_reg) ? AluSub : AluAdd;
      3'b001: op = AluSll;
      3'b010: op = AluSlt;
      3'b011: op = AluSltu;
      3'b100: op = AluXor;
      3'b101: op = alt ? AluSra : AluSrl;
      3'b110: op = AluOr;
      3'b111: op = AluAnd;
      default: op = AluAdd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctl_decode.sv
// Combinational RV32I instruction decoder.
// Inputs : opcode, funct3, funct7 fields of the instruction.
// Outputs: instr_class (instruction group), alu_op, imm_type, legal (opcode/funct7 valid).
module ctl_decode
  import cpu_ctl_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic [6:0]   funct7,
  output instr_class_e instr_class,
  output logic [3:0]   alu_op,
  output logic [2:0]   imm_type,
  output logic         legal
);

  logic alt;
  // Only the exact 0100000 pattern selects SUB/SRA
  assign alt = (funct7 == Funct7Alt);

  always_comb begin
    instr_class = ClsIllegal;
    alu_op      = AluAdd;
    imm_type    = ImmI;
    legal       = 1'b1;
    case (opcode)
      OpcodeOp: begin
        instr_class = ClsOp;
        alu_op      = alu_from_funct(funct3, alt, 1'b1);
        legal       = (funct7 == Funct7Base) || alt;
      end
      OpcodeOpImm: begin
        instr_class = ClsOpImm;
        alu_op      = alu_from_funct(funct3, alt, 1'b0);
      end
      OpcodeLoad:  instr_class = ClsLoad;
      OpcodeStore: begin
        instr_class = ClsStore;
        imm_type    = ImmS;
      end
      OpcodeBranch: begin
        instr_class = ClsBranch;
        alu_op      = AluSub;
        imm_type    = ImmB;
      end
      OpcodeJal: begin
        instr_class = ClsJal;
        imm_type    = ImmJ;
      end
      OpcodeJalr: instr_class = ClsJalr;
      OpcodeLui: begin
        instr_class = ClsLui;
        imm_type    = ImmU;
      end
      OpcodeAuipc: begin
        instr_class = ClsAuipc;
        imm_type    = ImmU;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXECUTE -> MEM -> WB, with a memory
// ready handshake, optional watchdog on mem_req, branch resolution and trap handling.
// Inputs : clk, rst_n, instr (memory read data), mem_ready, alu_zero/lt/ltu, trap_ack.
// Outputs: datapath enables (pc_write, ir_write, reg_write), memory request (mem_req,
//          mem_we, addr_sel), mux selects (alu_src_a/b, pc_src, wb_sel), alu_ctl, imm_type,
//          trap/trap_cause, busy.
module multicycle_control_unit
  import cpu_ctl_pkg::*;
#(
  parameter int unsigned ALU_CTL_W   = 4,
  parameter int unsigned IMM_TYPE_W  = 3,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter bit          TIMEOUT_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instr,
  input  logic                  mem_ready,
  input  logic                  alu_zero,
  input  logic                  alu_lt,
  input  logic                  alu_ltu,
  input  logic                  trap_ack,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  addr_sel,
  output logic                  reg_write,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTL_W-1:0]  alu_ctl,
  output logic [IMM_TYPE_W-1:0] imm_type,
  output logic [1:0]            pc_src,
  output logic [1:0]            wb_sel,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output logic                  busy
);

  ctl_state_e   state_q, state_d;
  logic [31:0]  ir_q;
  logic         run_q;  // low only in the idle FETCH cycle that follows reset
  logic [1:0]   cause_q, cause_d;
  logic [3:0]   alu_int;
  logic [2:0]   imm_int;
  instr_class_e dec_class;
  logic [3:0]   dec_alu_op;
  logic [2:0]   dec_imm_type;
  logic         dec_legal;
  logic         br_ok, br_taken;
  logic         timeout_hit;
  logic         unused_ir;

  // The datapath owns the operand/rd fields; only the control fields are decoded here
  assign unused_ir = ^{ir_q[24:15], ir_q[11:7]};

  ctl_decode u_decode (
    .opcode      (ir_q[6:0]),
    .funct3      (ir_q[14:12]),
    .funct7      (ir_q[31:25]),
    .instr_class (dec_class),
    .alu_op      (dec_alu_op),
    .imm_type    (dec_imm_type),
    .legal       (dec_legal)
  );

  always_comb begin
    br_ok    = 1'b1;
    br_taken = 1'b0;
    case (ir_q[14:12])
      3'b000:  br_taken = alu_zero;
      3'b001:  br_taken = !alu_zero;
      3'b100:  br_taken = alu_lt;
      3'b101:  br_taken = !alu_lt;
      3'b110:  br_taken = alu_ltu;
      3'b111:  br_taken = !alu_ltu;
      default: br_ok    = 1'b0;
    endcase
  end

  if (TIMEOUT_EN) begin : g_timeout
    logic [15:0] cnt_q, cnt_d;
    logic        mem_phase;

    assign mem_phase = (state_q == StMem) || ((state_q == StFetch) && run_q);
    // A ready in the final allowed cycle wins over the timeout
    assign timeout_hit = mem_phase && !mem_ready && (cnt_q == 16'(MEM_TIMEOUT - 1));

    always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
        cnt_d = '0;
      end else if (mem_phase && !mem_ready) begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    reg_write = 1'b0;
    alu_src_a = SrcARs1;
    alu_src_b = SrcBRs2;
    alu_int   = AluAdd;
    imm_int   = ImmI;
    pc_src    = PcPlus4;
    wb_sel    = WbAlu;
    case (state_q)
      StFetch: begin
        if (run_q) begin
          mem_req   = 1'b1;
          alu_src_a = SrcAPc;
          alu_src_b = SrcBFour;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = StDecode;
          end else if (timeout_hit) begin
            state_d = StTrap;
            cause_d = TrapTimeout;
          end
        end
      end
      StDecode: begin
        // Branch target PC_old + imm is formed here while rs1/rs2 are being read
        alu_src_a = SrcAPc;
        alu_src_b = SrcBImm;
        imm_int   = ImmB;
        if (dec_legal) begin
          state_d = StExecute;
        end else begin
          state_d = StTrap;
          cause_d = TrapIllegal;
        end
      end
      StExecute: begin
        alu_int = dec_alu_op;
        case (dec_class)
          ClsOp: state_d = StWb;
          ClsOpImm, ClsLoad, ClsStore: begin
            alu_src_b = SrcBImm;
            imm_int   = dec_imm_type;
            state_d   = (dec_class == ClsOpImm) ? StWb : StMem;
          end
          ClsBranch: begin
            if (br_ok) begin
              state_d = StFetch;
              if (br_taken) begin
                pc_write = 1'b1;
                pc_src   = PcBranch;
              end
            end else begin
              state_d = StTrap;
              cause_d = TrapIllegal;
            end
          end
          ClsJal, ClsJalr: begin
            alu_src_a = (dec_class == ClsJal) ? SrcAPc : SrcARs1;
            alu_src_b = SrcBImm;
            imm_int   = dec_imm_type;
            pc_write  = 1'b1;
            pc_src    = PcJump;
            state_d   = StWb;
          end
          ClsLui, ClsAuipc: begin
            alu_src_a = (dec_class == ClsLui) ? SrcAZero : SrcAPc;
            alu_src_b = SrcBImm;
            imm_int   = dec_imm_type;
            state_d   = StWb;
          end
          default: begin
            state_d = StTrap;
            cause_d = TrapIllegal;
          end
        endcase
      end
      StMem: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (dec_class == ClsStore);
        if (mem_ready) begin
          state_d = (dec_class == ClsStore) ? StFetch : StWb;
        end else if (timeout_hit) begin
          state_d = StTrap;
          cause_d = TrapTimeout;
        end
      end
      StWb: begin
        reg_write = 1'b1;
        if (dec_class == ClsLoad) begin
          wb_sel = WbMem;
        end else if ((dec_class == ClsJal) || (dec_class == ClsJalr)) begin
          wb_sel = WbPc4;
        end
        state_d = StFetch;
      end
      StTrap: begin
        if (trap_ack) begin
          state_d = StFetch;
          cause_d = TrapNone;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  assign alu_ctl    = ALU_CTL_W'(alu_int);
  assign imm_type   = IMM_TYPE_W'(imm_int);
  assign trap       = (state_q == StTrap);
  assign trap_cause = cause_q;
  assign busy       = run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      ir_q    <= '0;
      run_q   <= 1'b0;
      cause_q <= TrapNone;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      run_q   <= 1'b1;
      if (ir_write) begin
        ir_q <= instr;
      end
    end
  end

endmodule
